// File: rtl/regbank_write_arbiter.sv
// Register bank with one write port shared by two writeback requesters under
// round-robin arbitration, plus two combinational read ports.
module regbank_write_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  reqA,
    input  logic [ADDR_WIDTH-1:0] addrA,
    input  logic [DATA_WIDTH-1:0] dataA,
    output logic                  ackA,
    input  logic                  reqB,
    input  logic [ADDR_WIDTH-1:0] addrB,
    input  logic [DATA_WIDTH-1:0] dataB,
    output logic                  ackB,
    output logic                  prioB,
    input  logic [ADDR_WIDTH-1:0] rdAddr0,
    output logic [DATA_WIDTH-1:0] rdData0,
    input  logic [ADDR_WIDTH-1:0] rdAddr1,
    output logic [DATA_WIDTH-1:0] rdData1
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  prio_b_q;
    logic                  prio_b_d;
    logic                  grant_a;
    logic                  grant_b;

    // A wins when alone or when the pointer favours it; otherwise B takes any request.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset && !hold) begin
            if (reqA && (!reqB || !prio_b_q)) begin
                grant_a = 1'b1;
            end else if (reqB) begin
                grant_b = 1'b1;
            end
        end
    end

    always_comb begin
        regs_d   = regs_q;
        prio_b_d = prio_b_q;
        if (grant_a) begin
            regs_d[addrA] = dataA;
            prio_b_d      = 1'b1;
        end else if (grant_b) begin
            regs_d[addrB] = dataB;
            prio_b_d      = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            prio_b_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            prio_b_q <= prio_b_d;
        end
    end

    // Reads see only committed state, so a same-cycle write is not bypassed.
    assign ackA    = grant_a;
    assign ackB    = grant_b;
    assign prioB   = prio_b_q;
    assign rdData0 = regs_q[rdAddr0];
    assign rdData1 = regs_q[rdAddr1];

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Self-checking bench for regbank_write_arbiter: directed scenarios followed by
// randomized requester traffic, all checked against a behavioural model.
module tb_regbank_write_arbiter;

    logic        CLK = 1'b0;
    logic        reset, hold;
    logic        reqA, reqB;
    logic [2:0]  addrA, addrB, rdAddr0, rdAddr1;
    logic [15:0] dataA, dataB;
    logic        ackA, ackB, prioB;
    logic [15:0] rdData0, rdData1;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Model: register contents plus who was served last (0 none, 1 A, 2 B).
    logic [15:0] modelRegs [8];
    int          lastServed;

    logic        sAckA, sAckB, sPrio;
    logic [15:0] sRd0, sRd1;
    bit          expA, expB;

    regbank_write_arbiter #(.DATA_WIDTH(16), .NUM_REGS(8), .ADDR_WIDTH(3)) dut (
        .CLK(CLK), .reset(reset), .hold(hold),
        .reqA(reqA), .addrA(addrA), .dataA(dataA), .ackA(ackA),
        .reqB(reqB), .addrB(addrB), .dataB(dataB), .ackB(ackB),
        .prioB(prioB),
        .rdAddr0(rdAddr0), .rdData0(rdData0),
        .rdAddr1(rdAddr1), .rdData1(rdData1)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
    task automatic applyStimulus(input bit rst, input bit hld,
                                 input bit rA, input logic [2:0] aA, input logic [15:0] dA,
                                 input bit rB, input logic [2:0] aB, input logic [15:0] dB,
                                 input logic [2:0] r0, input logic [2:0] r1);
        bit wantA, wantB;
        reset = rst; hold = hld;
        reqA = rA; addrA = aA; dataA = dA;
        reqB = rB; addrB = aB; dataB = dB;
        rdAddr0 = r0; rdAddr1 = r1;
        @(negedge CLK);
        wantA = rA && !rst && !hld;
        wantB = rB && !rst && !hld;
        expA  = wantA && (!wantB || lastServed != 1);
        expB  = wantB && !expA;
        sAckA = ackA; sAckB = ackB; sPrio = prioB;
        sRd0  = rdData0; sRd1 = rdData1;
        checkOutput("ackA", {31'd0, sAckA}, {31'd0, expA});
        checkOutput("ackB", {31'd0, sAckB}, {31'd0, expB});
        checkOutput("prioB", {31'd0, sPrio}, {31'd0, lastServed == 1});
        checkOutput("rdData0", {16'd0, sRd0}, {16'd0, modelRegs[r0]});
        checkOutput("rdData1", {16'd0, sRd1}, {16'd0, modelRegs[r1]});
        @(posedge CLK);
        if (rst) begin
            foreach (modelRegs[i]) modelRegs[i] = 16'h0000;
            lastServed = 0;
        end else if (expA) begin
            modelRegs[aA] = dA;
            lastServed = 1;
        end else if (expB) begin
            modelRegs[aB] = dB;
            lastServed = 2;
        end
        #1;
    endtask

    function automatic logic [15:0] pickData();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        bit          pA, pB, rst, hld;
        logic [2:0]  aAr, aBr;
        logic [15:0] dAr, dBr;
        int          nA, nB;

        foreach (modelRegs[i]) modelRegs[i] = 16'h0000;
        lastServed = 0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 16'h1111, 1, 2, 16'h2222, 0, 7);

        // Reset clears an earlier write and suppresses a pending request.
        applyStimulus(0, 0, 1, 3, 16'h1234, 0, 0, 0, 3, 3);
        checkOutput("r3AckA", {31'd0, sAckA}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        checkOutput("r3Written", {16'd0, sRd0}, 32'h1234);
        applyStimulus(1, 0, 1, 5, 16'h5555, 1, 6, 16'h6666, 3, 0);
        checkOutput("rstAckA", {31'd0, sAckA}, 32'd0);
        checkOutput("rstAckB", {31'd0, sAckB}, 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 3, 3);
        checkOutput("r3AfterReset", {16'd0, sRd0}, 32'h0);
        checkOutput("prioAfterReset", {31'd0, sPrio}, 32'd0);

        // Signed extremes stored verbatim; old value visible during the ack cycle.
        applyStimulus(0, 0, 1, 5, 16'h8000, 0, 0, 0, 5, 5);
        checkOutput("r5OldInAck", {16'd0, sRd0}, 32'h0);
        applyStimulus(0, 0, 1, 5, 16'h7FFF, 0, 0, 0, 5, 5);
        checkOutput("r5Neg", {16'd0, sRd0}, 32'h8000);
        checkOutput("r5SecondAck", {31'd0, sAckA}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
        checkOutput("r5Pos", {16'd0, sRd1}, 32'h7FFF);

        // Contention straight out of reset: A first, then B.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 16'h00AA, 1, 2, 16'h00BB, 1, 2);
        checkOutput("ctnCyc1A", {31'd0, sAckA}, 32'd1);
        checkOutput("ctnCyc1B", {31'd0, sAckB}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 2, 16'h00BB, 1, 2);
        checkOutput("ctnPrio", {31'd0, sPrio}, 32'd1);
        checkOutput("ctnCyc2B", {31'd0, sAckB}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        checkOutput("ctnR1", {16'd0, sRd0}, 32'h00AA);
        checkOutput("ctnR2", {16'd0, sRd1}, 32'h00BB);

        // Both held for six transfers: grants must alternate starting with A.
        nA = 0; nB = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 1, 3'(2 * nA), 16'(16'hA000 + nA), 1, 3'(2 * nB + 1), 16'(16'hB000 + nB), 3'(i), 3'(7 - i));
            checkOutput($sformatf("fair%0dA", i), {31'd0, sAckA}, {31'd0, i % 2 == 0});
            checkOutput($sformatf("fair%0dB", i), {31'd0, sAckB}, {31'd0, i % 2 == 1});
            if (sAckA) nA++;
            if (sAckB) nB++;
        end

        // Same target with B preferred: B lands first, A's data survives.
        applyStimulus(0, 0, 1, 6, 16'h0606, 0, 0, 0, 6, 4);
        applyStimulus(0, 0, 1, 4, 16'h0001, 1, 4, 16'h0002, 6, 4);
        checkOutput("sameAddrFirstB", {31'd0, sAckB}, 32'd1);
        applyStimulus(0, 0, 1, 4, 16'h0001, 0, 0, 0, 4, 4);
        checkOutput("sameAddrMid", {16'd0, sRd0}, 32'h0002);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4, 4);
        checkOutput("sameAddrFinal", {16'd0, sRd0}, 32'h0001);

        // Hold freezes pointer and writes; release grants per the frozen pointer.
        applyStimulus(0, 0, 1, 7, 16'h0777, 0, 0, 0, 7, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 0, 16'hDEAD, 1, 7, 16'hBEEF, 0, 7);
            checkOutput("holdNoAck", {30'd0, sAckA, sAckB}, 32'd0);
            checkOutput("holdPrio", {31'd0, sPrio}, 32'd1);
        end
        applyStimulus(0, 0, 1, 0, 16'hDEAD, 1, 7, 16'hBEEF, 0, 7);
        checkOutput("holdReleaseB", {31'd0, sAckB}, 32'd1);
        applyStimulus(0, 0, 1, 0, 16'hDEAD, 0, 0, 0, 0, 7);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 7);

        // Randomized traffic obeying the handshake, with occasional hold and reset.
        pA = 0; pB = 0; aAr = 0; aBr = 0; dAr = 0; dBr = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!pA && $urandom_range(0, 2) != 0) begin
                pA = 1; aAr = 3'($urandom_range(0, 7)); dAr = pickData();
            end
            if (!pB && $urandom_range(0, 2) != 0) begin
                pB = 1; aBr = 3'($urandom_range(0, 7)); dBr = pickData();
            end
            rst = ($urandom_range(0, 39) == 0);
            hld = ($urandom_range(0, 4) == 0);
            applyStimulus(rst, hld, pA, aAr, dAr, pB, aBr, dBr,
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            if (expA) pA = 0;
            if (expB) pB = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
